// File: rtl/jtag_emu_pkg.sv
// Shared types and constants for the jtag_emu hardware shifter.
// Holds the FSM encoding, JTAG idle levels and the length clamp.
package jtag_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_TRST = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic TMS_IDLE = 1'b1;
  localparam logic TDI_IDLE = 1'b0;

  localparam int JTAG_MAX_BITS = 32;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > 6'(JTAG_MAX_BITS)) ? 6'(JTAG_MAX_BITS) : len;
  endfunction

endpackage

// File: rtl/jtag_emu_sync.sv
// Two-flop synchroniser, reset to 0.
// Used to bring the TAP's tdo back into the ps7 clock domain.
module jtag_emu_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_emu_shifter.sv
// Batched JTAG shifter: drives tck/tms/tdi/trstn from flops and
// returns up to 32 captured TDO bits per command.
module jtag_emu_shifter
  import jtag_emu_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int TRST_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_trst_i,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_tms_i,
  input  logic [31:0] cmd_tdi_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  output logic        busy_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  output logic        trstn_o,
  input  logic        tdo_i
);

  localparam logic [7:0] DIV_LD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] TRST_LD = 8'(TRST_LEN - 1);

  state_e      state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_idx;
  logic [5:0]  len_q;
  logic [31:0] tms_q;
  logic [31:0] tdi_q;
  logic [31:0] tdo_q;
  logic        tdo_sync;
  logic [5:0]  eff_len;
  logic [5:0]  bit_nxt;

  jtag_emu_sync u_tdo_sync (
    .clk (clk),
    .rst (rst),
    .d   (tdo_i),
    .q   (tdo_sync)
  );

  assign eff_len     = clamp_len(cmd_len_i);
  assign bit_nxt     = bit_idx + 6'd1;
  assign cmd_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign busy_o      = (state != ST_IDLE);
  assign rsp_tdo_o   = tdo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      len_q   <= '0;
      tms_q   <= '0;
      tdi_q   <= '0;
      tdo_q   <= '0;
      tck_o   <= 1'b0;
      tms_o   <= TMS_IDLE;
      tdi_o   <= TDI_IDLE;
      trstn_o <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            tdo_q   <= '0;
            bit_idx <= '0;
            len_q   <= eff_len;
            tms_q   <= cmd_tms_i;
            tdi_q   <= cmd_tdi_i;
            div_cnt <= DIV_LD;
            if (cmd_trst_i) begin
              state   <= ST_TRST;
              div_cnt <= TRST_LD;
              trstn_o <= 1'b0;
            end else if (eff_len == 6'd0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_LOW;
              tms_o <= cmd_tms_i[0];
              tdi_o <= cmd_tdi_i[0];
            end
          end
        end
        ST_LOW: begin
          if (div_cnt == 8'd0) begin
            // sample on the same clk edge that raises tck
            tdo_q[bit_idx[4:0]] <= tdo_sync;
            state   <= ST_HIGH;
            div_cnt <= DIV_LD;
            tck_o   <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_cnt == 8'd0) begin
            tck_o   <= 1'b0;
            div_cnt <= DIV_LD;
            if (bit_nxt < len_q) begin
              bit_idx <= bit_nxt;
              state   <= ST_LOW;
              tms_o   <= tms_q[bit_nxt[4:0]];
              tdi_o   <= tdi_q[bit_nxt[4:0]];
            end else begin
              state <= ST_RESP;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_TRST: begin
          if (div_cnt == 8'd0) begin
            trstn_o <= 1'b1;
            div_cnt <= DIV_LD;
            state   <= ST_RESP;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_emu_shifter.sv
// Directed bench for jtag_emu_shifter with a behavioural TAP model
// and a response scoreboard.
module tb_jtag_emu_shifter;

  localparam int D   = 4;
  localparam int TRL = 16;
  localparam logic [31:0] IDCODE = 32'h249511C3;

  localparam int TLR   = 0,  RTI   = 1,  SELDR = 2,  CAPDR = 3;
  localparam int SHDR  = 4,  EX1DR = 5,  PSDR  = 6,  EX2DR = 7;
  localparam int UPDR  = 8,  SELIR = 9,  CAPIR = 10, SHIR  = 11;
  localparam int EX1IR = 12, PSIR  = 13, EX2IR = 14, UPIR  = 15;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_trst_i;
  logic [5:0]  cmd_len_i;
  logic [31:0] cmd_tms_i;
  logic [31:0] cmd_tdi_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_tdo_o;
  logic        busy_o;
  logic        tck_o;
  logic        tms_o;
  logic        tdi_o;
  logic        trstn_o;
  logic        tdo_i;

  int n_chk;
  int n_fail;
  logic [31:0] exp_q[$];
  time rise_t[$];
  time fall_t[$];
  logic tms_at_rise[$];
  time t_acc;
  time t_rsp;
  int trst_cyc;

  int tap;
  logic [31:0] dr;

  jtag_emu_shifter #(
    .CLK_DIV  (D),
    .TRST_LEN (TRL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_trst_i  (cmd_trst_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_tms_i   (cmd_tms_i),
    .cmd_tdi_i   (cmd_tdi_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_tdo_o   (rsp_tdo_o),
    .busy_o      (busy_o),
    .tck_o       (tck_o),
    .tms_o       (tms_o),
    .tdi_o       (tdi_o),
    .trstn_o     (trstn_o),
    .tdo_i       (tdo_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tap_next(int s, logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PSDR;
      PSDR:    return m ? EX2DR : PSDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PSIR;
      PSIR:    return m ? EX2IR : PSIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  initial begin
    tap   = TLR;
    dr    = '0;
    tdo_i = 1'b0;
  end

  // TAP model: state and DR update on rising tck, tdo on falling tck
  always @(posedge tck_o or negedge trstn_o) begin
    if (!trstn_o) begin
      tap <= TLR;
    end else begin
      if (tap == CAPDR) dr <= IDCODE;
      if (tap == SHDR)  dr <= {tdi_o, dr[31:1]};
      tap <= tap_next(tap, tms_o);
    end
  end

  always @(negedge tck_o) begin
    tdo_i <= (tap == SHDR) ? dr[0] : 1'b0;
  end

  always @(posedge tck_o) begin
    rise_t.push_back($time);
    tms_at_rise.push_back(tms_o);
  end
  always @(negedge tck_o) fall_t.push_back($time);
  always @(posedge rsp_valid_o) t_rsp = $time;
  always @(posedge clk) if (trstn_o === 1'b0) trst_cyc++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    rise_t.delete();
    fall_t.delete();
    tms_at_rise.delete();
    trst_cyc = 0;
  endtask

  task automatic send_cmd(input logic trst, input logic [5:0] len,
                          input logic [31:0] tms, input logic [31:0] tdi,
                          input logic [31:0] exp);
    int n;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready_o}, 64'd1);
    clr_obs();
    cmd_valid_i = 1'b1;
    cmd_trst_i  = trst;
    cmd_len_i   = len;
    cmd_tms_i   = tms;
    cmd_tdi_i   = tdi;
    exp_q.push_back(exp);
    @(posedge clk);
    t_acc = $time;
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_valid_o !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("rsp_valid_wait", {63'd0, rsp_valid_o}, 64'd1);
  endtask

  task automatic take_rsp(input string tag);
    logic [31:0] e;
    wait_rsp();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    chk(tag, {32'd0, rsp_tdo_o}, {32'd0, e});
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    n_chk       = 0;
    n_fail      = 0;
    trst_cyc    = 0;
    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_trst_i  = 1'b0;
    cmd_len_i   = '0;
    cmd_tms_i   = '0;
    cmd_tdi_i   = '0;
    rsp_ready_i = 1'b0;
    repeat (3) tick();

    chk("reset_state",
        {57'd0, cmd_ready_o, rsp_valid_o, busy_o, tck_o, tms_o, tdi_o, trstn_o},
        {57'd0, 7'b1000_101});
    chk("reset_tdo", {32'd0, rsp_tdo_o}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: five TMS=1 clocks into Test-Logic-Reset
    send_cmd(1'b0, 6'd5, 32'h1F, 32'h0, 32'h0);
    wait_rsp();
    chk("t1_latency", 64'(t_rsp - t_acc), 64'(2 * 5 * D * 10));
    chk("t1_rises", 64'(rise_t.size()), 64'd5);
    for (int k = 0; k < 5 && k < rise_t.size(); k++) begin
      chk("t1_rise_time", 64'(rise_t[k] - t_acc), 64'((D + 2 * k * D) * 10));
      chk("t1_high_width", 64'(fall_t[k] - rise_t[k]), 64'(D * 10));
      chk("t1_tms", {63'd0, tms_at_rise[k]}, 64'd1);
    end
    chk("t1_tap_tlr", 64'(tap), 64'(TLR));
    take_rsp("t1_rsp");

    // 2: walk to Shift-DR, then read IDCODE and exit
    send_cmd(1'b0, 6'd4, 32'h2, 32'h0, 32'h0);
    take_rsp("t2_move_rsp");
    chk("t2_tap_shift", 64'(tap), 64'(SHDR));
    send_cmd(1'b0, 6'd32, 32'h8000_0000, 32'h0, IDCODE);
    wait_rsp();
    chk("t2_rises", 64'(rise_t.size()), 64'd32);
    chk("t2_tap_exit", 64'(tap), 64'(EX1DR));
    take_rsp("t2_idcode");

    // 3: TRST pulse
    send_cmd(1'b1, 6'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    wait_rsp();
    chk("t3_trst_cycles", 64'(trst_cyc), 64'(TRL));
    chk("t3_no_tck", 64'(rise_t.size()), 64'd0);
    chk("t3_tap_tlr", 64'(tap), 64'(TLR));
    take_rsp("t3_rsp");

    // 4: zero length, then clamped oversize length
    send_cmd(1'b0, 6'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    wait_rsp();
    chk("t4_len0_latency", 64'(t_rsp - t_acc), 64'd0);
    chk("t4_len0_no_tck", 64'(rise_t.size()), 64'd0);
    take_rsp("t4_len0_rsp");
    send_cmd(1'b0, 6'd40, 32'h0, 32'hA5A5_5A5A, 32'h0);
    wait_rsp();
    chk("t4_len40_rises", 64'(rise_t.size()), 64'd32);
    chk("t4_len40_latency", 64'(t_rsp - t_acc), 64'(2 * 32 * D * 10));
    take_rsp("t4_len40_rsp");

    // 5: response backpressure with a command waiting
    send_cmd(1'b0, 6'd3, 32'h0, 32'h4, 32'h0);
    wait_rsp();
    cmd_valid_i = 1'b1;
    cmd_trst_i  = 1'b0;
    cmd_len_i   = 6'd2;
    cmd_tms_i   = 32'h0;
    cmd_tdi_i   = 32'h0;
    clr_obs();
    for (int i = 0; i < 50; i++) begin
      chk("t5_hold",
          {26'd0, cmd_ready_o, rsp_valid_o, tck_o, tms_o, tdi_o, trstn_o,
           rsp_tdo_o},
          {26'd0, 6'b010011, 32'h0});
      tick();
    end
    chk("t5_no_tck", 64'(rise_t.size()), 64'd0);
    chk("t5_rsp", {32'd0, rsp_tdo_o}, {32'd0, exp_q.pop_front()});
    exp_q.push_back(32'h0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("t5_idle_after_hs", {62'd0, cmd_ready_o, busy_o}, 64'b10);
    tick();
    cmd_valid_i = 1'b0;
    chk("t5_next_accepted", {62'd0, cmd_ready_o, busy_o}, 64'b01);
    take_rsp("t5_next_rsp");

    // 6: reset while tck is high on bit 3
    send_cmd(1'b0, 6'd8, 32'h0, 32'hFF, 32'h0);
    void'(exp_q.pop_back());
    n = 0;
    while (rise_t.size() < 4 && n < 500) begin
      tick();
      n++;
    end
    chk("t6_reach_bit3", {62'd0, tck_o, tms_o}, 64'b10);
    rst = 1'b1;
    tick();
    chk("t6_after_rst",
        {58'd0, tck_o, tms_o, tdi_o, cmd_ready_o, rsp_valid_o, busy_o},
        {58'd0, 6'b010100});
    rst = 1'b0;
    repeat (3 * D) tick();
    chk("t6_no_rsp", {62'd0, rsp_valid_o, tck_o}, 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
